// File: rtl/seq_edge_gen_pkg.sv
// Shared types and constants for the 8-bit any-edge stimulus generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, bus width, width of per-cycle toggle counts,
// and a popcount helper used by the generator datapath.
package seq_edge_gen_pkg;

    localparam int NBITS = 8;
    // Wide enough to hold a popcount of 8 (needs 4 bits).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] popcount8(input logic [NBITS-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NBITS; i++) begin
            acc = acc + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/seq_edge_gen_sel.sv
// Picks the k lowest-indexed set bits of a lane mask.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   mask [7:0] in  - lanes allowed to toggle
//   k    [3:0] in  - number of lanes to pick (callers keep k <= popcount(mask))
//   sel  [7:0] out - the k lowest set bits of mask
module seq_edge_gen_sel
    import seq_edge_gen_pkg::*;
(
    input  logic [NBITS-1:0] mask,
    input  logic [CNT_W-1:0] k,
    output logic [NBITS-1:0] sel
);

    logic [CNT_W-1:0] taken;

    // Walk from bit 0 upward, granting set bits until k have been granted.
    always_comb begin
        sel   = '0;
        taken = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (mask[i] && (taken < k)) begin
                sel[i] = 1'b1;
                taken  = taken + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_edge_8b_any_gen.sv
// Drives an 8-bit bus so that it makes exactly N bit toggles, then pulses done.
// Latency: first toggle visible one edge after accept; done the cycle after the last toggle.
// Backpressure: req_rdy high only in IDLE with clear low; one request in flight at a time.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous active-low reset
//   clear          - synchronous abort back to IDLE (out_ held, no done)
//   req_val/req_rdy- request handshake; req_num (0..255) edges on lanes req_mask
//   out_   [7:0]   - generated bus, registered
//   done           - one-cycle completion pulse
//   err            - qualifies done: request had edges but an empty mask
//   total  [7:0]   - running toggle count (only with SEQ_EDGE_8B_ANY_GEN_TOTAL_EN)
//
// Build option: define SEQ_EDGE_8B_ANY_GEN_TOTAL_EN to add the total output,
// which tracks what a downstream any-edge counter would read.
module seq_edge_8b_any_gen
    import seq_edge_gen_pkg::*;
#(
    parameter int MAX_PER_CYCLE = 8    // legal range 1..8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_num,
    input  logic [NBITS-1:0] req_mask,
    output logic [NBITS-1:0] out_,
    output logic             done,
`ifdef SEQ_EDGE_8B_ANY_GEN_TOTAL_EN
    output logic             err,
    output logic [NBITS-1:0] total
`else
    output logic             err
`endif
);

    localparam logic [CNT_W-1:0] MAX_K = CNT_W'(MAX_PER_CYCLE);

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] rem;
    logic [NBITS-1:0] rem_nxt;
    logic [NBITS-1:0] mask_r;
    logic             err_r;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] k_cap;
    logic [CNT_W-1:0] k;
    logic [NBITS-1:0] sel;
    logic             accept;

    // ------------------------------------------------------------------
    // Per-cycle toggle budget: k = min(rem, popcount(mask), MAX_PER_CYCLE)
    // ------------------------------------------------------------------
    always_comb begin
        pc    = popcount8(mask_r);
        k_cap = (pc < MAX_K) ? pc : MAX_K;
        // rem below k_cap implies rem < 8, so its low nibble is the whole value.
        k     = (rem < {{(NBITS-CNT_W){1'b0}}, k_cap}) ? rem[CNT_W-1:0] : k_cap;
        rem_nxt = rem - {{(NBITS-CNT_W){1'b0}}, k};
    end

    seq_edge_gen_sel u_sel (
        .mask (mask_r),
        .k    (k),
        .sel  (sel)
    );

    assign accept = req_val && req_rdy;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    // Zero edges or no usable lanes finish immediately.
                    if ((req_num == '0) || (req_mask == '0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (rem_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // reset term keeps the requester off while the block is held in reset.
        req_rdy = reset && (state == IDLE) && !clear;
        done    = (state == DONE);
        err     = (state == DONE) && err_r;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem    <= '0;
            mask_r <= '0;
            err_r  <= 1'b0;
            out_   <= '0;
        end else if (clear) begin
            // Abort: drop remaining work, keep the bus where it is.
            rem   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem    <= req_num;
                        mask_r <= req_mask;
                        err_r  <= (req_num != '0) && (req_mask == '0);
                    end
                end
                EMIT: begin
                    out_ <= out_ ^ sel;
                    rem  <= rem_nxt;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_EDGE_8B_ANY_GEN_TOTAL_EN
    // Running edge count, wraps at 8 bits like the downstream counter would.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total <= '0;
        end else if (clear) begin
            total <= '0;
        end else if (state == EMIT) begin
            total <= total + {{(NBITS-CNT_W){1'b0}}, k};
        end
    end
`endif

endmodule

// File: doc/seq_edge_8b_any_gen.md
Name: seq_edge_8b_any_gen

Overview:
- Stimulus-side counterpart to the 8-bit any-edge counter.
- Accepts a request naming an edge count N and an 8-bit lane mask, then drives an 8-bit bus `out_` that produces exactly N bit toggles (rising plus falling, summed over all bits) before signalling done.
- A downstream any-edge counter fed by `out_` ends exactly N higher.
- Used as a traffic source in edge-counter subsystems and their benches.

Parameters:
- MAX_PER_CYCLE, 8, maximum bit toggles emitted in one cycle; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_num  in  8  number of edges to emit, 0..255.
- req_mask  in  8  lanes allowed to toggle.
- out_  out  8  generated bus, registered.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: request was impossible.

Behaviour:
- Reset (reset=0, async): state=IDLE, out_=0x00, rem=0, done=0, err=0. req_rdy=1 once reset deasserts.
- States:
  - IDLE: req_rdy = !clear.
  - EMIT: req_rdy=0.
  - DONE: req_rdy=0, done=1. err is the registered error flag.
- IDLE, on req_val && req_rdy at edge E0:
  - Latch num and mask; rem <= req_num.
  - req_num==0 -> DONE, err=0.
  - req_num>0 and req_mask==0 -> DONE, err=1.
  - Otherwise -> EMIT.
- EMIT, each edge:
  - k = min(rem, popcount(mask), MAX_PER_CYCLE).
  - sel = the k lowest-indexed set bits of mask.
  - out_ <= out_ ^ sel; rem <= rem - k.
  - If rem-k == 0 -> DONE.
- Latency: the first toggle is visible after E1; the final toggle is visible after the edge that enters DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE; the next request can be accepted one cycle later.
- out_ holds its value in IDLE and DONE. It is never reset by completion, only by reset.
- clear=1 at an edge:
  - Highest priority below reset, in any state.
  - Effects: state=IDLE, rem=0, out_ held, no done pulse.
  - When clear and req_val are both high in IDLE, the request is not accepted.
- req_val while not ready is ignored. The requester must hold req_num and req_mask until the handshake completes.
- Arithmetic: rem is 8-bit and never underflows, because k<=rem. k and popcount are 4-bit.
- Reset mid-EMIT: immediate return to the reset values; partial toggles are lost.

Optional Feature:
- Macro: SEQ_EDGE_8B_ANY_GEN_TOTAL_EN.
- When defined:
  - Adds output port `total` (8 bits, registered).
  - total <= total + k on every EMIT edge, with 8-bit wrap-around.
  - Reset or clear sets total to 0.
  - Mirrors the value a downstream any-edge counter would hold.
- When undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package seq_edge_gen_pkg holds:
  - state enum {IDLE, EMIT, DONE} (2 bits).
  - constant NBITS=8.
  - constant CNT_W=4 for k/popcount.
- Sub-module seq_edge_gen_sel (combinational): inputs mask[7:0] and k[3:0]; outputs sel[7:0] with the k lowest set bits of mask.
- Main module: FSM, rem, and registers.

Test Plan:
- mask=0x01, num=3, MAX=8 -> out_ 00,01,00,01 after E1..E3; done=1 the cycle after E3, err=0; req_rdy=1 after E4.
- mask=0xFF, num=20, MAX=8 -> out_ FF,00,0F after E1..E3; done=1 the next cycle.
- mask=0x55, num=6, MAX=2 -> out_ 05,00,05; done next cycle. Confirms the per-cycle cap and the lowest-bit selection order.
- num=0 (done, err=0) and mask=0x00 with num=5 (done, err=1) -> done the cycle after accept; out_ unchanged.
- mask=0x01, num=10, clear asserted after 2 toggles -> IDLE, out_=0x00 held, no done, req_rdy=1. With the feature enabled, total=0.
- reset low mid-EMIT with out_=0x0F -> out_=0x00 and req_rdy=0 immediately (asynchronous). After release, a request with mask=0x80, num=1 gives out_=0x80 and done.
